// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response channel between execute stage and load_store_unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian load/store unit with alignment/range checks and sub-word RMW
// Optional perf counters (load_cnt/store_cnt/err_cnt) when LSU_PERF_EN is defined.
module load_store_unit #(
  parameter int MEM_BYTES = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  lsu,
  output logic [31:0]       dm_add,
  output logic [31:0]       dm_data_in,
  output logic              dm_wen,
  input  logic [31:0]       dm_data_out
`ifdef LSU_PERF_EN
  ,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        dm_wen_q;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        req_err;
  logic        accept;
  logic        resp_fire;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign lsu.req_ready  = (state == IDLE);
  assign accept         = lsu.req_valid && (state == IDLE);
  assign resp_fire      = resp_valid_q && lsu.resp_ready;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_err   = resp_err_q;
  assign lsu.resp_rdata = resp_rdata_q;
  // Gate with reset so a store in flight cannot reach memory on the reset edge.
  assign dm_wen         = dm_wen_q & rst_n;

  always_comb begin
    nbytes = 3'd1;
    case (lsu.req_size)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    end_addr = {1'b0, lsu.req_addr} + {30'd0, nbytes};
    req_err  = 1'b0;
    if (lsu.req_size == 2'b11)                                req_err = 1'b1;
    if ((lsu.req_size == 2'b01) && lsu.req_addr[0])           req_err = 1'b1;
    if ((lsu.req_size == 2'b10) && (lsu.req_addr[1:0] != 0))  req_err = 1'b1;
    if (end_addr > 33'(MEM_BYTES))                            req_err = 1'b1;
  end

  // Lane selection is big-endian: offset 0 is the most significant byte.
  always_comb begin
    lane_b = 8'd0;
    case (off_q)
      2'd0:    lane_b = dm_data_out[31:24];
      2'd1:    lane_b = dm_data_out[23:16];
      2'd2:    lane_b = dm_data_out[15:8];
      default: lane_b = dm_data_out[7:0];
    endcase
    lane_h = off_q[1] ? dm_data_out[15:0] : dm_data_out[31:16];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = dm_data_out;
    endcase
    merged = dm_data_out;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      wdata_q      <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      dm_wen_q     <= 1'b0;
      dm_data_in   <= 32'd0;
      dm_add       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= lsu.req_we;
            uns_q   <= lsu.req_unsigned;
            size_q  <= lsu.req_size;
            off_q   <= lsu.req_addr[1:0];
            wdata_q <= lsu.req_wdata[15:0];
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
              state        <= RESP;
            end else begin
              dm_add <= {lsu.req_addr[31:2], 2'b00};
              if (lsu.req_we && (lsu.req_size == 2'b10)) begin
                dm_wen_q   <= 1'b1;
                dm_data_in <= lsu.req_wdata;
              end
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (we_q && (size_q != 2'b10)) begin
            dm_data_in <= merged;
            dm_wen_q   <= 1'b1;
            state      <= WRITE;
          end else begin
            resp_rdata_q <= we_q ? 32'd0 : load_val;
            resp_valid_q <= 1'b1;
            dm_wen_q     <= 1'b0;
            dm_data_in   <= 32'd0;
            dm_add       <= 32'd0;
            state        <= RESP;
          end
        end
        WRITE: begin
          dm_wen_q     <= 1'b0;
          dm_data_in   <= 32'd0;
          dm_add       <= 32'd0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (lsu.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else if (resp_fire) begin
      if (resp_err_q) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (we_q) begin
        if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
      end else begin
        if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;
  logic        clk;
  logic        rst_n;
  logic [31:0] dm_add;
  logic [31:0] dm_data_in;
  logic        dm_wen;
  logic [31:0] dm_data_out;
  logic        preload_req;
  logic [7:0]  mem_b   [0:255];
  logic [7:0]  ref_mem [0:255];
  int          checks;
  int          failures;
  int          n_load;
  int          n_store;
  int          n_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wens;
    logic [31:0] wadd;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb_q[$];

  load_store_unit_if bus();

`ifdef LSU_PERF_EN
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
  logic [15:0] err_cnt;
`endif

  load_store_unit #(.MEM_BYTES(256), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu         (bus.slave),
    .dm_add      (dm_add),
    .dm_data_in  (dm_data_in),
    .dm_wen      (dm_wen),
    .dm_data_out (dm_data_out)
`ifdef LSU_PERF_EN
    ,
    .load_cnt    (load_cnt),
    .store_cnt   (store_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] wa;
  assign wa = {dm_add[7:2], 2'b00};
  assign dm_data_out = {mem_b[wa], mem_b[wa + 8'd1], mem_b[wa + 8'd2], mem_b[wa + 8'd3]};

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'h02;
      mem_b[0] <= 8'h00; mem_b[1] <= 8'h02; mem_b[2] <= 8'h03; mem_b[3] <= 8'h02;
    end else if (dm_wen) begin
      mem_b[wa]        <= dm_data_in[31:24];
      mem_b[wa + 8'd1] <= dm_data_in[23:16];
      mem_b[wa + 8'd2] <= dm_data_in[15:8];
      mem_b[wa + 8'd3] <= dm_data_in[7:0];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem_b[a], mem_b[a + 1], mem_b[a + 2], mem_b[a + 3]};
  endfunction

  task automatic preload();
    @(negedge clk);
    preload_req = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h02;
    ref_mem[0] = 8'h00; ref_mem[1] = 8'h02; ref_mem[2] = 8'h03; ref_mem[3] = 8'h02;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    exp_t        e;
    exp_t        got;
    longint      nb;
    int          a;
    logic [15:0] h;
    logic [31:0] hold_rdata;
    logic        hold_err;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a  = int'(addr[7:0]);
    e.err   = (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
              ((size == 2'b10) && (addr[1:0] != 2'b00)) || ((longint'(addr) + nb) > 256);
    e.rdata = 32'd0;
    e.wens  = 0;
    e.wadd  = 32'd0;
    e.wdata = 32'd0;
    e.lat   = e.err ? 1 : (we && size != 2'b10) ? 3 : 2;
    if (!e.err && !we) begin
      if (size == 2'b00) e.rdata = uns ? {24'd0, ref_mem[a]} : {{24{ref_mem[a][7]}}, ref_mem[a]};
      else if (size == 2'b01) begin
        h = {ref_mem[a], ref_mem[a + 1]};
        e.rdata = uns ? {16'd0, h} : {{16{h[15]}}, h};
      end else e.rdata = {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
    end
    if (!e.err && we) begin
      if (size == 2'b00) ref_mem[a] = wdata[7:0];
      else if (size == 2'b01) begin ref_mem[a] = wdata[15:8]; ref_mem[a + 1] = wdata[7:0]; end
      else begin
        ref_mem[a] = wdata[31:24]; ref_mem[a + 1] = wdata[23:16];
        ref_mem[a + 2] = wdata[15:8]; ref_mem[a + 3] = wdata[7:0];
      end
      e.wens  = 1;
      e.wadd  = {addr[31:2], 2'b00};
      e.wdata = {ref_mem[a & 252], ref_mem[(a & 252) + 1], ref_mem[(a & 252) + 2], ref_mem[(a & 252) + 3]};
    end
    sb_q.push_back(e);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    got.lat = 1; got.wens = 0; got.wadd = 32'd0; got.wdata = 32'd0;
    while (1) begin
      if (dm_wen) begin got.wens++; got.wadd = dm_add; got.wdata = dm_data_in; end
      if (bus.resp_valid || got.lat >= 10) break;
      @(negedge clk);
      got.lat++;
    end
    e = sb_q.pop_front();
    check_eq("resp_valid", 32'(bus.resp_valid), 32'd1);
    check_eq("latency", 32'(got.lat), 32'(e.lat));
    check_eq("rdata", bus.resp_rdata, e.rdata);
    check_eq("err", 32'(bus.resp_err), 32'(e.err));
    check_eq("wen_cycles", 32'(got.wens), 32'(e.wens));
    if (e.wens > 0) begin
      check_eq("wr_add", got.wadd, e.wadd);
      check_eq("wr_data", got.wdata, e.wdata);
    end
    hold_rdata = bus.resp_rdata;
    hold_err   = bus.resp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.resp_valid), 32'd1);
      check_eq("stall_rdata", bus.resp_rdata, hold_rdata);
      check_eq("stall_err", 32'(bus.resp_err), 32'(hold_err));
      check_eq("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    if (e.err) n_err++; else if (we) n_store++; else n_load++;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_eq("resp_release", 32'(bus.resp_valid), 32'd0);
    check_eq("back_idle", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check_eq({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    check_eq({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    check_eq({tag, "_dm_wen"}, 32'(dm_wen), 32'd0);
    check_eq({tag, "_dm_data_in"}, dm_data_in, 32'd0);
    check_eq({tag, "_dm_add"}, dm_add, 32'd0);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic reset_in_access(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = size;
    bus.req_unsigned = 1'b0; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_access_wen", 32'(dm_wen), 32'd0);
    @(negedge clk);
    check_eq("rst_no_write", 32'(dm_wen), 32'd0);
    check_reset_outputs("rst_access");
    rst_n = 1'b1;
    n_load = 0; n_store = 0; n_err = 0;
  endtask

  initial begin
    checks = 0; failures = 0; n_load = 0; n_store = 0; n_err = 0;
    rst_n = 1'b0; preload_req = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
    preload();
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h80, 0);
    check_eq("sb_word4", mem_word(4), 32'h02800202);
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 0);

    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'hFE, 32'h0, 0);

    preload();
    do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234ABCD, 0);
    check_eq("sh_word4", mem_word(4), 32'h0202ABCD);
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 0);

    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 3);
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 1);
    do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 0);

    reset_in_access(2'b00, 32'h5, 32'h11);
    do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 0);
    reset_in_access(2'b10, 32'h8, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0);

    for (int i = 0; i < 24; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 263)), $urandom, $urandom_range(0, 2));
    end
    for (int i = 0; i < 256; i += 4) begin
      check_eq("final_mem", mem_word(i), {ref_mem[i], ref_mem[i + 1], ref_mem[i + 2], ref_mem[i + 3]});
    end

`ifdef LSU_PERF_EN
    check_eq("load_cnt", 32'(load_cnt), 32'(n_load));
    check_eq("store_cnt", 32'(store_cnt), 32'(n_store));
    check_eq("err_cnt", 32'(err_cnt), 32'(n_err));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
